// File: rtl/sprite_pkg.sv
// sprite_pkg: shared defaults, screen limits and the sprite descriptor record.
package sprite_pkg;
  localparam int NUM_SPRITES_DEF = 8;
  localparam int ELEMENT_W_DEF = 5;
  localparam int SIZE_LOG2_DEF = 5;
  localparam int ADDR_W_DEF = 10;
  localparam int SCREEN_W = 800;
  localparam int SCREEN_H = 600;
  localparam int X_W = $clog2(SCREEN_W) + 1;
  localparam int Y_W = $clog2(SCREEN_H);
  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic visible;
  } sprite_t;
endpackage

// File: rtl/sprite_hit.sv
// sprite_hit: per-channel coverage test and texel offsets for the current pixel.
module sprite_hit
  import sprite_pkg::*;
#(
  parameter int SIZE_LOG2 = SIZE_LOG2_DEF
) (
  input  sprite_t              desc_i,
  input  logic                 active_i,
  input  logic [X_W-1:0]       pixel_x_i,
  input  logic [Y_W-1:0]       pixel_y_i,
  output logic                 hit_o,
  output logic [SIZE_LOG2-1:0] off_x_o,
  output logic [SIZE_LOG2-1:0] off_y_o
);
  localparam logic [X_W:0] SPAN_X = (X_W+1)'((1 << SIZE_LOG2) - 1);
  localparam logic [Y_W:0] SPAN_Y = (Y_W+1)'((1 << SIZE_LOG2) - 1);
  logic [X_W:0] x_end;
  logic [Y_W:0] y_end;
  // one extra bit keeps sprites near the far edge from wrapping to 0
  assign x_end = {1'b0, desc_i.x} + SPAN_X;
  assign y_end = {1'b0, desc_i.y} + SPAN_Y;
  assign hit_o = desc_i.visible & active_i &
                 (pixel_x_i >= desc_i.x) & ({1'b0, pixel_x_i} <= x_end) &
                 (pixel_y_i >= desc_i.y) & ({1'b0, pixel_y_i} <= y_end);
  assign off_x_o = pixel_x_i[SIZE_LOG2-1:0] - desc_i.x[SIZE_LOG2-1:0];
  assign off_y_o = pixel_y_i[SIZE_LOG2-1:0] - desc_i.y[SIZE_LOG2-1:0];
endmodule

// File: rtl/sprite_compositor.sv
// sprite_compositor: two-stage fixed-priority sprite overlay with per-frame
// collision flags against channel 0.
module sprite_compositor
  import sprite_pkg::*;
#(
  parameter int NUM_SPRITES = NUM_SPRITES_DEF,
  parameter int ELEMENT_W = ELEMENT_W_DEF,
  parameter int SIZE_LOG2 = SIZE_LOG2_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           active,
  input  logic                           frame_start,
  input  logic [X_W-1:0]                 pixel_x,
  input  logic [Y_W-1:0]                 pixel_y,
  input  logic                           wr_valid,
  output logic                           wr_ready,
  input  logic [$clog2(NUM_SPRITES)-1:0] wr_index,
  input  logic [X_W-1:0]                 wr_x,
  input  logic [Y_W-1:0]                 wr_y,
  input  logic [ELEMENT_W-1:0]           wr_element,
  input  logic                           wr_visible,
  output logic                           ready,
  output logic [ELEMENT_W-1:0]           element,
  output logic [ADDR_W-1:0]              address,
  output logic [$clog2(NUM_SPRITES)-1:0] hit_index,
  output logic [NUM_SPRITES-1:0]         collision
);
  localparam int IW = $clog2(NUM_SPRITES);
  localparam logic [IW:0] NS = (IW+1)'(NUM_SPRITES);
  sprite_t desc_q [NUM_SPRITES];
  logic [ELEMENT_W-1:0] elem_q [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] hit_d, hit_q, collision_d, collision_q;
  logic [SIZE_LOG2-1:0] offx_d [NUM_SPRITES];
  logic [SIZE_LOG2-1:0] offy_d [NUM_SPRITES];
  logic [SIZE_LOG2-1:0] offx_q [NUM_SPRITES];
  logic [SIZE_LOG2-1:0] offy_q [NUM_SPRITES];
  logic ready_d, ready_q;
  logic [ELEMENT_W-1:0] element_d, element_q;
  logic [ADDR_W-1:0] address_d, address_q;
  logic [IW-1:0] hit_index_d, hit_index_q;
  logic wr_take;
  // descriptors only change in blanking so a visible frame never tears
  assign wr_ready = ~active & ~reset;
  assign wr_take = wr_valid & wr_ready & ({1'b0, wr_index} < NS);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        desc_q[i] <= '0;
        elem_q[i] <= '0;
      end
    end else if (wr_take) begin
      desc_q[wr_index] <= '{x: wr_x, y: wr_y, visible: wr_visible};
      elem_q[wr_index] <= wr_element;
    end
  end
  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_hit
    sprite_hit #(.SIZE_LOG2(SIZE_LOG2)) u_hit (
      .desc_i   (desc_q[g]),
      .active_i (active),
      .pixel_x_i(pixel_x),
      .pixel_y_i(pixel_y),
      .hit_o    (hit_d[g]),
      .off_x_o  (offx_d[g]),
      .off_y_o  (offy_d[g])
    );
  end
  always_comb begin
    ready_d = 1'b0;
    element_d = '0;
    address_d = '0;
    hit_index_d = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (hit_q[i]) begin
        ready_d = 1'b1;
        element_d = elem_q[i];
        address_d = ADDR_W'({offy_q[i], offx_q[i]});
        hit_index_d = IW'(i);
      end
    end
    collision_d = (frame_start ? '0 : collision_q) |
                  (hit_q[0] ? {hit_q[NUM_SPRITES-1:1], 1'b0} : '0);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_q <= '0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        offx_q[i] <= '0;
        offy_q[i] <= '0;
      end
      ready_q <= 1'b0;
      element_q <= '0;
      address_q <= '0;
      hit_index_q <= '0;
      collision_q <= '0;
    end else begin
      hit_q <= hit_d;
      offx_q <= offx_d;
      offy_q <= offy_d;
      ready_q <= ready_d;
      element_q <= element_d;
      address_q <= address_d;
      hit_index_q <= hit_index_d;
      collision_q <= collision_d;
    end
  end
  assign ready = ready_q;
  assign element = element_q;
  assign address = address_q;
  assign hit_index = hit_index_q;
  assign collision = collision_q;
endmodule

// File: tb/tb_sprite_compositor.sv
// tb_sprite_compositor: directed and randomized checks of the sprite compositor
// against a coverage/priority model kept as plain integer descriptors.
module tb_sprite_compositor;
  localparam int NS = 6;
  logic clk = 0, reset = 1, active = 0, frame_start = 0;
  logic [10:0] pixel_x = 0, wr_x = 0;
  logic [9:0] pixel_y = 0, wr_y = 0;
  logic wr_valid = 0, wr_ready, wr_visible = 0, ready;
  logic [2:0] wr_index = 0, hit_index;
  logic [4:0] wr_element = 0, element;
  logic [9:0] address;
  logic [NS-1:0] collision;
  int errors = 0, checks = 0;
  int mx [NS], my [NS], me [NS];
  bit mv [NS];

  sprite_compositor #(.NUM_SPRITES(NS)) dut (
    .clk(clk), .reset(reset), .active(active), .frame_start(frame_start),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_index(wr_index), .wr_x(wr_x), .wr_y(wr_y), .wr_element(wr_element),
    .wr_visible(wr_visible), .ready(ready), .element(element), .address(address),
    .hit_index(hit_index), .collision(collision)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  function automatic bit covers(input int i, input int px, input int py, input bit act);
    return mv[i] && act && px >= mx[i] && px <= mx[i] + 31 && py >= my[i] && py <= my[i] + 31;
  endfunction

  function automatic logic [18:0] exp_vec(input int px, input int py, input bit act);
    for (int i = 0; i < NS; i++)
      if (covers(i, px, py, act))
        return {1'b1, me[i][4:0], 10'((py - my[i]) * 32 + (px - mx[i])), i[2:0]};
    return '0;
  endfunction

  function automatic logic [NS-1:0] exp_hits(input int px, input int py, input bit act);
    logic [NS-1:0] h = '0;
    for (int i = 0; i < NS; i++) h[i] = covers(i, px, py, act);
    return h;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < NS; i++) begin
      mx[i] = 0; my[i] = 0; me[i] = 0; mv[i] = 0;
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int idx, input int x, input int y, input int el, input bit vis);
    active = 0;
    wr_valid = 1;
    wr_index = idx[2:0];
    wr_x = x[10:0];
    wr_y = y[9:0];
    wr_element = el[4:0];
    wr_visible = vis;
    step();
    wr_valid = 0;
    if (idx < NS) begin
      mx[idx] = x; my[idx] = y; me[idx] = el; mv[idx] = vis;
    end
  endtask

  task automatic drive_px(input int px, input int py, input bit act);
    active = act;
    pixel_x = px[10:0];
    pixel_y = py[9:0];
    step();
    step();
    active = 0;
  endtask

  task automatic test_reset();
    model_clear();
    reset = 1;
    active = 0;
    step();
    checks++;
    if ({ready, element, address, hit_index, collision, wr_ready} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0",
               {ready, element, address, hit_index, collision, wr_ready});
    end
    reset = 0;
    step();
    checks++;
    if (wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_wr_ready: got %b required 1", wr_ready);
    end
  endtask

  task automatic test_basic();
    do_write(0, 100, 100, 3, 1);
    drive_px(105, 102, 1);
    checks++;
    if ({ready, element, address, hit_index} !== {1'b1, 5'd3, 10'd69, 3'd0}) begin
      errors++;
      $display("FAIL basic_hit: got r=%b e=%0d a=%0d i=%0d required r=1 e=3 a=69 i=0",
               ready, element, address, hit_index);
    end
    drive_px(99, 102, 1);
    checks++;
    if ({ready, element, address, hit_index} !== exp_vec(99, 102, 1)) begin
      errors++;
      $display("FAIL basic_left_miss: got %h required %h",
               {ready, element, address, hit_index}, exp_vec(99, 102, 1));
    end
    drive_px(105, 102, 0);
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL inactive_miss: got ready=%b required 0", ready);
    end
  endtask

  task automatic test_priority();
    do_write(1, 190, 190, 7, 1);
    do_write(2, 195, 195, 9, 1);
    drive_px(200, 200, 1);
    checks++;
    if ({ready, element, address, hit_index} !== {1'b1, 5'd7, 10'((10 << 5) | 10), 3'd1}) begin
      errors++;
      $display("FAIL priority_low: got e=%0d a=%0d i=%0d required e=7 a=330 i=1",
               element, address, hit_index);
    end
    do_write(1, 190, 190, 7, 0);
    drive_px(200, 200, 1);
    checks++;
    if ({ready, element, address, hit_index} !== {1'b1, 5'd9, 10'd165, 3'd2}) begin
      errors++;
      $display("FAIL priority_invisible: got e=%0d a=%0d i=%0d required e=9 a=165 i=2",
               element, address, hit_index);
    end
  endtask

  task automatic test_edge();
    do_write(3, 790, 400, 4, 1);
    drive_px(5, 410, 1);
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL edge_no_wrap_x: got ready=%b required 0", ready);
    end
    drive_px(799, 410, 1);
    checks++;
    if (ready !== 1'b1 || address[4:0] !== 5'd9 || hit_index !== 3'd3) begin
      errors++;
      $display("FAIL edge_right: got r=%b a=%0d i=%0d required r=1 a[4:0]=9 i=3",
               ready, address, hit_index);
    end
    do_write(3, 2030, 400, 4, 1);
    drive_px(3, 410, 1);
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL wrap_x_11bit: got ready=%b required 0", ready);
    end
    do_write(4, 100, 1000, 2, 1);
    drive_px(110, 3, 1);
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL wrap_y_10bit: got ready=%b required 0", ready);
    end
    drive_px(131, 1023, 1);
    checks++;
    if ({ready, element, address, hit_index} !== exp_vec(131, 1023, 1)) begin
      errors++;
      $display("FAIL edge_bottom: got %h required %h",
               {ready, element, address, hit_index}, exp_vec(131, 1023, 1));
    end
  endtask

  task automatic test_write_gating();
    active = 1;
    wr_valid = 1;
    wr_index = 3'd5;
    wr_x = 11'd50;
    wr_y = 10'd50;
    wr_element = 5'd1;
    wr_visible = 1;
    #1;
    checks++;
    if (wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL wr_ready_active: got %b required 0", wr_ready);
    end
    step();
    step();
    wr_valid = 0;
    drive_px(55, 55, 1);
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL write_blocked: got ready=%b required 0", ready);
    end
    active = 0;
    wr_valid = 1;
    #1;
    checks++;
    if (wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL wr_ready_blank: got %b required 1", wr_ready);
    end
    step();
    wr_valid = 0;
    mx[5] = 50; my[5] = 50; me[5] = 1; mv[5] = 1;
    drive_px(55, 55, 1);
    checks++;
    if ({ready, element, address, hit_index} !== {1'b1, 5'd1, 10'd165, 3'd5}) begin
      errors++;
      $display("FAIL write_taken: got r=%b e=%0d a=%0d i=%0d required r=1 e=1 a=165 i=5",
               ready, element, address, hit_index);
    end
    do_write(6, 400, 400, 8, 1);
    do_write(7, 400, 400, 8, 1);
    drive_px(405, 405, 1);
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL out_of_range_write: got ready=%b required 0", ready);
    end
  endtask

  task automatic test_collision();
    active = 0;
    frame_start = 1;
    step();
    frame_start = 0;
    step();
    checks++;
    if (collision !== '0) begin
      errors++;
      $display("FAIL collision_clear_idle: got %h required 0", collision);
    end
    do_write(3, 131, 131, 5, 1);
    do_write(4, 70, 70, 6, 1);
    drive_px(131, 131, 1);
    checks++;
    if (collision !== 6'h08 || hit_index !== 3'd0) begin
      errors++;
      $display("FAIL collision_ch3: got col=%h i=%0d required col=08 i=0", collision, hit_index);
    end
    drive_px(100, 100, 1);
    checks++;
    if (collision !== 6'h18) begin
      errors++;
      $display("FAIL collision_sticky: got %h required 18", collision);
    end
    active = 1;
    pixel_x = 131;
    pixel_y = 131;
    step();
    active = 0;
    frame_start = 1;
    step();
    frame_start = 0;
    checks++;
    if (collision !== 6'h08) begin
      errors++;
      $display("FAIL collision_frame_overlap: got %h required 08", collision);
    end
    active = 1;
    pixel_x = 131;
    pixel_y = 130;
    step();
    active = 0;
    frame_start = 1;
    step();
    frame_start = 0;
    checks++;
    if (collision !== 6'h00) begin
      errors++;
      $display("FAIL collision_frame_clear: got %h required 00", collision);
    end
  endtask

  task automatic test_random();
    logic [NS+18:0] q[$];
    logic [NS+18:0] e;
    logic [NS-1:0] exp_col = '0;
    logic [NS-1:0] h;
    int px, py;
    bit act;
    for (int i = 0; i < NS; i++)
      do_write(i, $urandom_range(200, 80), $urandom_range(200, 80),
               $urandom_range(31, 0), $urandom_range(3, 0) != 0);
    frame_start = 1;
    step();
    frame_start = 0;
    step();
    for (int k = 0; k < 300; k++) begin
      px = $urandom_range(240, 70);
      py = $urandom_range(240, 70);
      act = $urandom_range(7, 0) != 0;
      active = act;
      pixel_x = px[10:0];
      pixel_y = py[9:0];
      h = exp_hits(px, py, act);
      if (h[0]) exp_col = exp_col | (h & ~NS'(1));
      q.push_back({exp_col, exp_vec(px, py, act)});
      step();
      if (q.size() == 2) begin
        e = q.pop_front();
        checks++;
        if ({collision, ready, element, address, hit_index} !== e) begin
          errors++;
          $display("FAIL random_pixel %0d: got %h required %h", k,
                   {collision, ready, element, address, hit_index}, e);
        end
      end
    end
    active = 0;
    step();
    e = q.pop_front();
    checks++;
    if ({collision, ready, element, address, hit_index} !== e) begin
      errors++;
      $display("FAIL random_tail: got %h required %h",
               {collision, ready, element, address, hit_index}, e);
    end
  endtask

  task automatic test_reset_mid();
    do_write(0, 300, 300, 6, 1);
    drive_px(310, 310, 1);
    checks++;
    if ({ready, element, address, hit_index} !== {1'b1, 5'd6, 10'd330, 3'd0}) begin
      errors++;
      $display("FAIL pre_reset_hit: got r=%b e=%0d a=%0d required r=1 e=6 a=330",
               ready, element, address);
    end
    active = 1;
    pixel_x = 310;
    pixel_y = 310;
    #2;
    reset = 1;
    active = 0;
    wr_valid = 1;
    wr_index = 3'd1;
    wr_x = 11'd300;
    wr_y = 10'd300;
    wr_visible = 1;
    #1;
    checks++;
    if ({ready, element, address, hit_index, collision, wr_ready} !== '0) begin
      errors++;
      $display("FAIL reset_async: got %h required 0",
               {ready, element, address, hit_index, collision, wr_ready});
    end
    step();
    reset = 0;
    wr_valid = 0;
    model_clear();
    drive_px(310, 310, 1);
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_miss: got ready=%b required 0", ready);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_edge();
    test_write_gating();
    test_collision();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
